// File: rtl/mips_pkg.sv
// Shared MIPS definitions: datapath widths, ALU funct encodings and
// a helper that classifies shift-by-immediate functs.
package mips_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int FUNCT_WIDTH    = 6;
    localparam int SHAMT_WIDTH    = 5;

    // R-type funct field encodings understood by the ALU
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL  = 6'b000000;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRL  = 6'b000010;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRA  = 6'b000011;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD  = 6'b100000;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADDU = 6'b100001;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUB  = 6'b100010;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUBU = 6'b100011;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_AND  = 6'b100100;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_OR   = 6'b100101;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_XOR  = 6'b100110;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_NOR  = 6'b100111;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLT  = 6'b101010;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLTU = 6'b101011;

    // Shift-by-shamt instructions take the value to shift from rt and the
    // shift distance from the shamt field rather than from a register.
    function automatic logic is_shamt_shift(input logic [FUNCT_WIDTH-1:0] funct);
        return (funct == FUNCT_SLL) || (funct == FUNCT_SRL) || (funct == FUNCT_SRA);
    endfunction

endpackage

// File: rtl/forward_mux.sv
// Per-operand bypass selector: picks EX/MEM, then MEM/WB, then the
// registered register-file value. Register 0 is hard-wired and never bypassed.
module forward_mux
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH
) (
    input  logic [REG_ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0]     reg_data,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic [DATA_WIDTH-1:0]     fwd_data
);

    logic src_nonzero;
    assign src_nonzero = (src_addr != '0);

    // Select the youngest in-flight producer of src_addr, EX/MEM first
    always_comb begin
        // NOTE: assigning a default before any branch guarantees every path
        // drives the output, so no latch is inferred.
        fwd_data = reg_data;
        if (src_nonzero && exmem_reg_write && (exmem_rd_addr == src_addr)) begin
            fwd_data = exmem_result;
        end else if (src_nonzero && memwb_reg_write && (memwb_rd_addr == src_addr)) begin
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register feeding the ALU. Registers one decoded instruction
// per cycle, bypasses results from EX/MEM and MEM/WB, snoops those bypass
// buses while stalled, and maps operands into the ALU's A/B convention.
module alu_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH,
    parameter int FUNCT_WIDTH    = mips_pkg::FUNCT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FUNCT_WIDTH-1:0]    in_funct,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] in_rt_addr,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
    input  logic [DATA_WIDTH-1:0]     in_rs_data,
    input  logic [DATA_WIDTH-1:0]     in_rt_data,
    input  logic [4:0]                in_shamt,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic                      in_use_imm,
    input  logic                      in_reg_write,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [FUNCT_WIDTH-1:0]    alu_operation,
    output logic [DATA_WIDTH-1:0]     alu_operandA,
    output logic [DATA_WIDTH-1:0]     alu_operandB,
    output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
    output logic                      out_reg_write
);

    // Registered instruction fields
    logic                      valid_q;
    logic [FUNCT_WIDTH-1:0]    funct_q;
    logic [REG_ADDR_WIDTH-1:0] rs_addr_q;
    logic [REG_ADDR_WIDTH-1:0] rt_addr_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0]     rs_data_q;
    logic [DATA_WIDTH-1:0]     rt_data_q;
    logic [4:0]                shamt_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic                      use_imm_q;
    logic                      reg_write_q;

    // Bypassed source values
    logic [DATA_WIDTH-1:0] rs_fwd;
    logic [DATA_WIDTH-1:0] rt_fwd;

    // An empty stage always fills, even under stall
    assign in_ready = !valid_q || !stall;

    forward_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs (
        .src_addr        (rs_addr_q),
        .reg_data        (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .fwd_data        (rs_fwd)
    );

    forward_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rt (
        .src_addr        (rt_addr_q),
        .reg_data        (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .fwd_data        (rt_fwd)
    );

    // Pipeline register: reset, flush, load, or hold-and-snoop while stalled
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            valid_q     <= 1'b0;
            funct_q     <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            shamt_q     <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q     <= in_valid;
            funct_q     <= in_funct;
            rs_addr_q   <= in_rs_addr;
            rt_addr_q   <= in_rt_addr;
            rd_addr_q   <= in_rd_addr;
            rs_data_q   <= in_rs_data;
            rt_data_q   <= in_rt_data;
            shamt_q     <= in_shamt;
            imm_q       <= in_imm;
            use_imm_q   <= in_use_imm;
            reg_write_q <= in_reg_write;
        end else begin
            // Capture any producer retiring during the stall so it is not
            // lost once it leaves the bypass buses.
            rs_data_q <= rs_fwd;
            rt_data_q <= rt_fwd;
        end
    end

    // Map bypassed sources into the ALU's operand convention
    always_comb begin
        alu_operandA = rs_fwd;
        alu_operandB = use_imm_q ? imm_q : rt_fwd;
        if (is_shamt_shift(funct_q)) begin
            alu_operandA = rt_fwd;
            alu_operandB = {{(DATA_WIDTH-5){1'b0}}, shamt_q};
        end
    end

    assign out_valid     = valid_q;
    assign alu_operation = funct_q;
    assign out_rd_addr   = rd_addr_q;
    assign out_reg_write = valid_q && reg_write_q;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It accepts one decoded instruction per cycle from the decode stage and registers its funct, operands and destination information. It resolves data hazards by forwarding from the EX/MEM and MEM/WB stages, then presents `operation`, `operandA` and `operandB` to the ALU in the ALU's operand convention. It supports stall and flush from the hazard unit and never loses forwarded data while stalled.

## Interface
- `DATA_WIDTH`, 32, operand and result width
- `REG_ADDR_WIDTH`, 5, register-file address width
- `FUNCT_WIDTH`, 6, ALU operation code width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  decode stage presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_funct`  in  6  ALU operation (MIPS funct encoding)
- `in_rs_addr`, `in_rt_addr`, `in_rd_addr`  in  5 each  source and destination registers
- `in_rs_data`, `in_rt_data`  in  32 each  register-file read data
- `in_shamt`  in  5  shift amount field
- `in_imm`  in  32  immediate, already extended by decode
- `in_use_imm`  in  1  operand B comes from `in_imm`
- `in_reg_write`  in  1  instruction writes `in_rd_addr`
- `exmem_reg_write`, `exmem_rd_addr`, `exmem_result`  in  1/5/32  EX/MEM forwarding source
- `memwb_reg_write`, `memwb_rd_addr`, `memwb_result`  in  1/5/32  MEM/WB forwarding source
- `stall`  in  1  hold the current contents
- `flush`  in  1  kill the current contents
- `out_valid`  out  1  outputs hold a live instruction
- `alu_operation`  out  6  to ALU `operation`
- `alu_operandA`, `alu_operandB`  out  32 each  to ALU `operandA` / `operandB`
- `out_rd_addr`  out  5  destination register, carried to EX/MEM
- `out_reg_write`  out  1  write enable, forced to 0 when `out_valid`=0

## Operation
- Accept happens when `in_valid && in_ready`. `in_ready = !out_valid || !stall`.
- Each rising edge is evaluated in priority order:
  - `!rst_n` clears all registers.
  - `flush` sets `out_valid`=0 and drops any simultaneous accept.
  - `!stall || !out_valid` sets `out_valid <= in_valid` and loads all fields.
  - Otherwise, while held, the registered rs/rt data is overwritten with any matching forward value (snoop). A producer that retires during a stall is therefore not lost.
- Forwarding is applied per source operand, combinationally on registered data:
  - EX/MEM is used if `exmem_reg_write && exmem_rd_addr == src && src != 0`.
  - Else MEM/WB is used under the same rule.
  - Else the registered data is used.
  - Register 0 is never forwarded.
- Operand mapping:
  - Shift functs `000000` (sll), `000010` (srl), `000011` (sra): A = forwarded rt, B = zero-extended shamt.
  - Otherwise: A = forwarded rs; B = `in_imm` if `use_imm`, else forwarded rt.
- `alu_operation` is the registered funct. Unrecognised functs pass through unchanged; the ALU handles them.
- A bubble (`out_valid`=0) drives `out_reg_write`=0. The other outputs hold stale values and are don't-care.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is on the outputs after edge N.
- Forward muxes add combinational delay only; there is no extra cycle.
- Reset values: `out_valid`=0, `out_reg_write`=0, `alu_operation`=0, operands=0, `out_rd_addr`=0, `in_ready`=1.
- Throughput is one instruction per cycle when `stall`=0.
- Stall with the stage empty: the input is still accepted, because the stage fills.
- `flush` and `stall` together: flush wins.
- Reset mid-stall clears the stage; the next cycle accepts normally.
- EX/MEM and MEM/WB hitting the same register: EX/MEM wins.

## Structure
- Shared package `mips_pkg`:
  - funct constants `FUNCT_SLL`/`SRL`/`SRA`/`ADD`/`ADDU`/`SUB`/`SUBU`/`AND`/`OR`/`XOR`/`NOR`/`SLT`/`SLTU`
  - width constants
- Sub-module `forward_mux`, instantiated twice (rs, rt). Inputs are src address, registered data and both forwarding sources; output is the selected data.

## Test plan
- **Reset:** hold `rst_n`=0 with `in_valid`=1. Required: `out_valid`=0, `in_ready`=1, all outputs 0.
- **Plain add:** funct `100000`, rs=1 data 5, rt=2 data 7, no forwarding. Required: next cycle A=5, B=7, `alu_operation`=`100000`, `out_valid`=1.
- **Forward priority:** rs=3 with `exmem` rd=3 result 100 and `memwb` rd=3 result 200. Required: A=100. With `exmem_reg_write`=0: A=200. With rs=0 and both forwarding to reg 0: A=`in_rs_data`.
- **Shift mapping:** sra, rt data `0x80000000`, shamt 20. Required: A=`0x80000000`, B=20.
- **Stall snoop:**
  - Stage holds rt=4 and `stall`=1.
  - MEM/WB writes r4=`0xDEAD` for one cycle, then stops forwarding.
  - After releasing the stall, B must equal `0xDEAD`.
  - `in_ready`=0 throughout the stall.
- **Flush:** flush with `in_valid`=1 and `stall`=1. Required: `out_valid`=0 and `out_reg_write`=0 next cycle, input dropped.
